smul32_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 32x32 signed multiplier core among NREQ requesters. Each requester submits an operand pair with a valid/ready handshake. The block grants one request at a time, registers the operands, and registers the exact 64-bit two's-complement product. It then returns the result tagged with the requester index through a single response channel with backpressure. It sits between the issuing units and the combinational signed multiplier datapath.

---
 rtl/smul32_pkg.sv | 34 +++
 rtl/smul32_core.sv | 18 +
 rtl/smul32_arbiter.sv | 125 ++++++++++++
 tb/tb_smul32_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/smul32_pkg.sv
// Shared constants, FSM state encoding and round-robin pick helper for the smul32 arbiter.
package smul32_pkg;

    localparam int unsigned OP_W    = 32;
    localparam int unsigned PROD_W  = 64;
    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned MAX_IDW = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // First set bit at or after ptr, searching upward modulo nreq; 0 when req is empty.
    function automatic logic [MAX_IDW-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [MAX_IDW-1:0] ptr,
        input int unsigned        nreq
    );
        logic        found;
        int unsigned idx;
        rr_pick = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            idx = (32'(ptr) + i) % nreq;
            if (!found && (i < nreq) && req[idx]) begin
                rr_pick = MAX_IDW'(idx);
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/smul32_core.sv
// Purely combinational exact signed 32x32 -> 64 multiplier.
module smul32_core
    import smul32_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] p_c
);

    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] b_ext;

    // Sign-extend first so the low 64 bits of the product are exact.
    assign a_ext = PROD_W'($signed(a));
    assign b_ext = PROD_W'($signed(b));
    assign p_c   = a_ext * b_ext;

endmodule

// File: rtl/smul32_arbiter.sv
// Round-robin arbiter sharing one signed 32x32 multiplier among NREQ requesters.
// Optional per-requester grant counters are enabled with SMUL32_ARB_CNT_EN.
module smul32_arbiter
    import smul32_pkg::*;
#(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [OP_W*NREQ-1:0]   req_a,
    input  logic [OP_W*NREQ-1:0]   req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [PROD_W-1:0]      rsp_p,
    output logic                   busy
`ifdef SMUL32_ARB_CNT_EN
    ,
    output logic [16*NREQ-1:0]     grant_cnt
`endif
);

    state_e              state_q,     state_d;
    logic [IDW-1:0]      rr_ptr_q,    rr_ptr_d;
    logic [OP_W-1:0]     op_a_q,      op_a_d;
    logic [OP_W-1:0]     op_b_q,      op_b_d;
    logic [IDW-1:0]      rsp_id_q,    rsp_id_d;
    logic [PROD_W-1:0]   rsp_p_q,     rsp_p_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                busy_q,      busy_d;
    logic [IDW-1:0]      win_c;
    logic [PROD_W-1:0]   prod_c;
`ifdef SMUL32_ARB_CNT_EN
    logic [16*NREQ-1:0]  cnt_q,       cnt_d;
`endif

    smul32_core u_core (
        .a   (op_a_q),
        .b   (op_b_q),
        .p_c (prod_c)
    );

    assign win_c = IDW'(rr_pick(MAX_REQ'(req_valid), MAX_IDW'(rr_ptr_q), NREQ));

    // Next-state and datapath capture.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        rsp_id_d  = rsp_id_q;
        rsp_p_d   = rsp_p_q;
        req_ready = '0;
`ifdef SMUL32_ARB_CNT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    req_ready[win_c] = 1'b1;
                    op_a_d   = req_a[32'(win_c)*OP_W +: OP_W];
                    op_b_d   = req_b[32'(win_c)*OP_W +: OP_W];
                    rsp_id_d = win_c;
                    rr_ptr_d = (win_c == IDW'(NREQ-1)) ? '0 : win_c + IDW'(1);
                    state_d  = ST_MUL;
`ifdef SMUL32_ARB_CNT_EN
                    cnt_d[32'(win_c)*16 +: 16] = cnt_q[32'(win_c)*16 +: 16] + 16'd1;
`endif
                end
            end
            ST_MUL: begin
                rsp_p_d = prod_c;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        rsp_valid_d = (state_d == ST_RESP);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            rsp_id_q    <= '0;
            rsp_p_q     <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SMUL32_ARB_CNT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            rsp_id_q    <= rsp_id_d;
            rsp_p_q     <= rsp_p_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
`ifdef SMUL32_ARB_CNT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_p     = rsp_p_q;
    assign busy      = busy_q;
`ifdef SMUL32_ARB_CNT_EN
    assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_smul32_arbiter.sv
// Scoreboard bench for smul32_arbiter: directed operand vectors with hand-computed products.
module tb_smul32_arbiter;

    localparam int unsigned NREQ = 4;

    typedef struct {
        logic [1:0]  id;
        logic [63:0] p;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [32*NREQ-1:0]  req_a;
    logic [32*NREQ-1:0]  req_b;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [1:0]          rsp_id;
    logic [63:0]         rsp_p;
    logic                busy;
`ifdef SMUL32_ARB_CNT_EN
    logic [16*NREQ-1:0]  grant_cnt;
`endif

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    smul32_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p),
        .busy      (busy)
`ifdef SMUL32_ARB_CNT_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_op(input int k, input logic [31:0] a, input logic [31:0] b);
        req_a[32*k +: 32] = a;
        req_b[32*k +: 32] = b;
    endtask

    task automatic push_exp(input int k, input logic [63:0] p);
        exp_t e;
        e.id = 2'(k);
        e.p  = p;
        exp_q.push_back(e);
    endtask

    // Waits (bounded) for a grant, checks it, returns just after the accept edge.
    task automatic wait_grant(input logic [NREQ-1:0] exp_rdy, input int maxc);
        bit seen = 1'b0;
        for (int i = 0; i < maxc && !seen; i++) begin
            @(negedge clk);
            if (req_ready != '0) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: got none expected 0x%0h", exp_rdy);
        end else begin
            chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int k, input logic [31:0] a, input logic [31:0] b, input logic [63:0] p);
        set_op(k, a, b);
        req_valid = NREQ'(1) << k;
        push_exp(k, p);
        wait_grant(NREQ'(1) << k, 10);
        req_valid = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every response handshake.
    always @(negedge clk) begin
        if (!rst && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got id=%0d p=0x%0h expected no response", rsp_id, rsp_p);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_id", 64'(rsp_id), 64'(mon_e.id));
                chk("rsp_p", rsp_p, mon_e.p);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        do_reset();

        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_rsp_p", rsp_p, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;

        // Single op with latency check: accept at t, rsp_valid at t+2.
        issue(2, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
        @(negedge clk);
        chk("mul_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mul_busy", 64'(busy), 64'd1);
        @(negedge clk);
        chk("lat_rsp_valid", 64'(rsp_valid), 64'd1);
        @(posedge clk);
        #1;

        // Extreme operands.
        issue(0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        issue(1, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000);

        // Round-robin fairness from a fresh pointer.
        repeat (4) @(posedge clk);
        #1;
        do_reset();
        set_op(0, 32'd100, 32'd200);
        set_op(1, 32'hFFFF_FFFB, 32'hFFFF_FFFA);
        set_op(2, 32'h0001_0000, 32'h0001_0000);
        set_op(3, 32'hFFFF_FFFF, 32'h7FFF_FFFF);
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            case (k % 4)
                0: push_exp(0, 64'h0000_0000_0000_4E20);
                1: push_exp(1, 64'h0000_0000_0000_001E);
                2: push_exp(2, 64'h0000_0001_0000_0000);
                default: push_exp(3, 64'hFFFF_FFFF_8000_0001);
            endcase
            wait_grant(NREQ'(1) << (k % 4), 10);
        end
        req_valid = '0;
        repeat (4) @(posedge clk);
        #1;

        // Backpressure: response held for 10 cycles while requester 3 waits.
        rsp_ready = 1'b0;
        issue(1, 32'd12345, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_CFC7);
        set_op(3, 32'd3, 32'd4);
        req_valid = 4'b1000;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_rsp_id", 64'(rsp_id), 64'd1);
            chk("bp_rsp_p", rsp_p, 64'hFFFF_FFFF_FFFF_CFC7);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        push_exp(3, 64'h0000_0000_0000_000C);
        @(posedge clk);
        @(negedge clk);
        chk("bp_next_grant", 64'(req_ready), 64'b1000);
        @(posedge clk);
        #1 req_valid = '0;
        repeat (4) @(posedge clk);
        #1;

        // Reset in the MUL cycle aborts; pointer returns to 0 so requester 1 wins over 3.
        set_op(2, 32'd9, 32'd9);
        req_valid = 4'b0100;
        wait_grant(4'b0100, 10);
        rst = 1'b1;
        set_op(1, 32'hFFFF_FFFE, 32'd3);
        set_op(3, 32'd5, 32'd5);
        req_valid = 4'b1010;
        push_exp(1, 64'hFFFF_FFFF_FFFF_FFFA);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_grant", 64'(req_ready), 64'b0010);
        @(posedge clk);
        #1 req_valid = '0;
        repeat (4) @(posedge clk);
        #1;

`ifdef SMUL32_ARB_CNT_EN
        do_reset();
        issue(0, 32'd1, 32'd1, 64'd1);
        issue(0, 32'd2, 32'd1, 64'd2);
        issue(3, 32'd3, 32'd1, 64'd3);
        issue(0, 32'd4, 32'd1, 64'd4);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("grant_cnt", grant_cnt, {16'd1, 16'd0, 16'd0, 16'd3});
        @(posedge clk);
        #1;
        do_reset();
        @(negedge clk);
        chk("grant_cnt_rst", grant_cnt, 64'd0);
`endif

        repeat (10) @(posedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
